dcache_dm_refill: RTL and testbench

Parametrised direct-mapped, write-through, no-write-allocate data cache with a handshaked backing-memory port. It sits between the core's load/store stage and word-addressed main memory. Read misses are refilled critical-word-first with wrap-around, and writes stall the core until memory accepts them. Geometry is configurable, and the block adds a flush, which the fixed 4-line design lacks.

---
 rtl/dcache_dm_refill.sv | 190 +++++++++++++++++++
 tb/tb_dcache_dm_refill.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm_refill.sv
// Direct-mapped write-through, no-write-allocate data cache with critical-word-first refill.
// Latency: read hit 0 cycles; read miss W+1 stall cycles plus memory wait; write 2 cycles plus memory wait.
// Backpressure: IsStall holds the core while a refill or write is outstanding; memory throttles via mem_ack.
module dcache_dm_refill #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2,
  parameter int OFF_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              flush,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  output logic              IsStall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LINES = 1 << IDX_W;
  localparam int WORDS = 1 << OFF_W;
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Address fields of the current core request
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;

  assign req_tag = addr[ADDR_W-1:IDX_W+OFF_W];
  assign req_idx = addr[IDX_W+OFF_W-1:OFF_W];
  assign req_off = addr[OFF_W-1:0];

  // Line storage: valid bits are reset, tags and data are not
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES][WORDS];

  // Refill progress; the fill offset wraps inside the line so the requested word arrives first
  logic [OFF_W-1:0] beat;
  logic [OFF_W-1:0] fill_off;
  logic             flush_pend;

  assign fill_off = req_off + beat;

  // Lookup against the current contents; updates only become visible after the edge
  assign hit   = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign rdata = (hit && MemRead) ? data_mem[req_idx][req_off] : '0;

  // Transaction strobes shared by the state, valid and storage updates
  logic miss_start;
  logic fill_ack;
  logic fill_done;
  logic wr_done;
  logic back_idle;
  logic flush_apply;

  assign miss_start  = (state == IDLE) && !MemWrite && MemRead && !hit;
  assign fill_ack    = (state == REFILL) && mem_ack;
  assign fill_done   = fill_ack && (beat == LAST_BEAT);
  assign wr_done     = (state == WRITE) && mem_ack;
  assign back_idle   = fill_done || wr_done;
  // A flush seen while busy is deferred to the cycle the FSM returns to IDLE
  assign flush_apply = ((state == IDLE) && flush) || (back_idle && (flush_pend || flush));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection; stores win over loads when both are requested
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (MemWrite) begin
          state_nxt = WRITE;
        end else if (MemRead && !hit) begin
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        if (fill_done) begin
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port and core stall outputs, decoded from the current state only
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    IsStall   = 1'b1;
    case (state)
      IDLE: begin
        IsStall = (MemRead && !hit) || MemWrite;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, fill_off};
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
      end
      default: begin
        IsStall = 1'b1;
      end
    endcase
  end

  // Beat counter and deferred-flush flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat       <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (miss_start) begin
        beat <= '0;
      end else if (fill_ack) begin
        beat <= beat + OFF_W'(1);
      end

      if (state == IDLE || back_idle) begin
        flush_pend <= 1'b0;
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

  // Valid bits: a line under refill is invalid until its last beat lands, and a flush overrides the set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (flush_apply) begin
      valid <= '0;
    end else if (miss_start) begin
      valid[req_idx] <= 1'b0;
    end else if (fill_done) begin
      valid[req_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: refill beats fill the line, write hits update the cached word in place
  always_ff @(posedge clk) begin
    if (fill_ack) begin
      data_mem[req_idx][fill_off] <= mem_rdata;
    end
    if (fill_done) begin
      tag_mem[req_idx] <= req_tag;
    end
    if (wr_done && hit) begin
      data_mem[req_idx][req_off] <= wdata;
    end
  end

endmodule

// File: tb/tb_dcache_dm_refill.sv
// Directed bench for dcache_dm_refill: a memory responder with programmable wait states,
// expected memory transactions and load results queued by the stimulus, and a negedge
// monitor that pops and compares whenever the cache issues a beat or returns load data.
module tb_dcache_dm_refill;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemRead;
  logic        MemWrite;
  logic        flush;
  logic [31:0] rdata;
  logic        hit;
  logic        IsStall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  dcache_dm_refill #(
    .ADDR_W(32),
    .DATA_W(32),
    .IDX_W (2),
    .OFF_W (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .flush    (flush),
    .rdata    (rdata),
    .hit      (hit),
    .IsStall  (IsStall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  mem_exp_t    exp_mem[$];
  logic [31:0] exp_load[$];
  mem_exp_t    e;
  logic [31:0] el;

  int checks = 0;
  int fails  = 0;
  int mem_wait = 0;
  int wcnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Memory stub: reads return 0xA0 + word offset; acks after mem_wait idle cycles per request
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (wcnt < mem_wait) begin
      mem_ack = 1'b0;
      wcnt++;
    end else begin
      mem_ack = 1'b1;
      wcnt = 0;
      mem_rdata = 32'hA0 + {30'd0, mem_addr[1:0]};
      if (exp_mem.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_mem_req: got we=%0b addr=%0h expected none", mem_we, mem_addr);
      end else begin
        e = exp_mem.pop_front();
        check("mem_we", {63'd0, mem_we}, {63'd0, e.we});
        check("mem_addr", {32'd0, mem_addr}, {32'd0, e.addr});
        if (e.we) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.wdata});
      end
    end
    if (!rst && MemRead && hit && !IsStall) begin
      if (exp_load.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_load: got rdata=%0h expected none", rdata);
      end else begin
        el = exp_load.pop_front();
        check("load_rdata", {32'd0, rdata}, {32'd0, el});
      end
    end
  end

  task automatic push_refill(input logic [31:0] a);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] o;
      mem_exp_t   m;
      o = a[1:0] + k[1:0];
      m.we = 1'b0;
      m.addr = {a[31:2], o};
      m.wdata = 32'd0;
      exp_mem.push_back(m);
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic exp_hit, input logic [31:0] exp_data,
                         input int exp_stalls, input int flush_at, input int n_refills);
    int stalls;
    int guard;
    int fa;
    exp_load.push_back(exp_data);
    for (int r = 0; r < n_refills; r++) push_refill(a);
    fa = flush_at;
    @(posedge clk);
    #1;
    addr = a;
    MemRead = 1'b1;
    if (fa >= 0) begin
      fork
        begin
          repeat (fa) @(posedge clk);
          #1 flush = 1'b1;
          @(posedge clk);
          #1 flush = 1'b0;
        end
      join_none
    end
    @(negedge clk);
    check("hit_first", {63'd0, hit}, {63'd0, exp_hit});
    stalls = 0;
    guard = 0;
    while (IsStall && guard < 60) begin
      stalls++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 60) begin
      checks++;
      fails++;
      $display("FAIL load_timeout: got stall after %0d cycles expected release", guard);
    end
    check("load_stalls", 64'(stalls), 64'(exp_stalls));
    @(posedge clk);
    #1;
    MemRead = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int waits, input int exp_stalls);
    int stalls;
    int guard;
    mem_exp_t m;
    m.we = 1'b1;
    m.addr = a;
    m.wdata = d;
    exp_mem.push_back(m);
    mem_wait = waits;
    @(posedge clk);
    #1;
    addr = a;
    wdata = d;
    MemWrite = 1'b1;
    stalls = 0;
    guard = 0;
    while (guard < 60) begin
      @(negedge clk);
      guard++;
      if (IsStall) stalls++;
      #1;
      if (mem_ack) break;
    end
    if (guard >= 60) begin
      checks++;
      fails++;
      $display("FAIL write_timeout: got no ack after %0d cycles expected ack", guard);
    end
    check("write_stalls", 64'(stalls), 64'(exp_stalls));
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    mem_wait = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    addr = 32'd0;
    wdata = 32'd0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    flush = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;

    // Outputs while held in reset
    #12;
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    check("rst_hit", {63'd0, hit}, 64'd0);
    check("rst_stall_idle", {63'd0, IsStall}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    MemRead = 1'b1;
    #1;
    check("rst_stall_read", {63'd0, IsStall}, 64'd1);
    MemRead = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Cold miss at 0x25: beats 0x25,0x26,0x27,0x24, 5 stall cycles, then 0xA1
    do_load(32'h25, 1'b0, 32'hA1, 5, -1, 1);
    // Hit in the same line, no memory traffic
    do_load(32'h27, 1'b1, 32'hA3, 0, -1, 0);
    // Write hit with two memory wait cycles, then read back
    do_write(32'h24, 32'hDEAD, 2, 4);
    do_load(32'h24, 1'b1, 32'hDEAD, 0, -1, 0);
    // Write miss does not allocate: the following read of 0x35 misses
    do_write(32'h35, 32'h1234, 0, 2);
    do_load(32'h35, 1'b0, 32'hA1, 5, -1, 1);
    // Conflict eviction on index 1
    do_load(32'h25, 1'b0, 32'hA1, 5, -1, 1);
    do_load(32'h65, 1'b0, 32'hA1, 5, -1, 1);
    do_load(32'h25, 1'b0, 32'hA1, 5, -1, 1);
    // Flush in IDLE coinciding with a hit still returns data
    do_load(32'h25, 1'b1, 32'hA1, 0, 0, 0);
    // Flush during beat 2: refill completes invalid, so the read re-misses and refills twice
    do_load(32'h25, 1'b0, 32'hA1, 10, 3, 2);

    // Reset after two beats of a refill of 0x65
    begin
      mem_exp_t m;
      m.we = 1'b0;
      m.wdata = 32'd0;
      m.addr = 32'h65;
      exp_mem.push_back(m);
      m.addr = 32'h66;
      exp_mem.push_back(m);
    end
    @(posedge clk);
    #1;
    addr = 32'h65;
    MemRead = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_mem_req", {63'd0, mem_req}, 64'd0);
    MemRead = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // All lines invalid after reset: 0x25 needs a full refill
    do_load(32'h25, 1'b0, 32'hA1, 5, -1, 1);

    repeat (3) @(posedge clk);
    check("mem_queue_empty", 64'(exp_mem.size()), 64'd0);
    check("load_queue_empty", 64'(exp_load.size()), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
